// File: rtl/ex_ctrl_sequencer.sv
// Registered ID->EX control stage: decode, load-use stall, multi-cycle MDU sequencing, flush.
// Define RISCV_M_EXT_EN to enable the MUL/DIV path; otherwise M-extension ops decode as illegal.
module ex_ctrl_sequencer #(
  parameter int ALU_OP_WIDTH = 6,
  parameter int INSTR_WIDTH  = 7,
  parameter int MUL_CYCLES   = 2,
  parameter int DIV_CYCLES   = 34
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid_i,
  output logic                    id_ready_o,
  input  logic [INSTR_WIDTH-1:0]  decoded_instr_i,
  input  logic [4:0]              rd_i,
  input  logic [4:0]              rs1_i,
  input  logic [4:0]              rs2_i,
  input  logic                    flush_i,
  output logic                    ex_valid_o,
  input  logic                    ex_ready_i,
  output logic [ALU_OP_WIDTH-1:0] alu_op_o,
  output logic [2:0]              load_type_o,
  output logic [1:0]              store_type_o,
  output logic                    write_en_o,
  output logic                    stype_o,
  output logic                    imm_alu_o,
  output logic                    jalr_o,
  output logic                    jal_o,
  output logic                    branch_o,
  output logic                    auipc_o,
  output logic                    lui_o,
  output logic                    zeroflag_inv_o,
  output logic                    mdu_sel_o,
  output logic [4:0]              ex_rd_o,
  output logic                    mdu_start_o,
  output logic                    mdu_busy_o,
  output logic                    illegal_instr_o
);

  typedef logic [INSTR_WIDTH-1:0]  instr_t;
  typedef logic [ALU_OP_WIDTH-1:0] aop_t;

  localparam instr_t I_LUI  = instr_t'(1),  I_AUIPC = instr_t'(2),  I_JAL  = instr_t'(3),  I_JALR  = instr_t'(4);
  localparam instr_t I_BEQ  = instr_t'(5),  I_BNE   = instr_t'(6),  I_BLT  = instr_t'(7),  I_BGE   = instr_t'(8);
  localparam instr_t I_BLTU = instr_t'(9),  I_BGEU  = instr_t'(10), I_LB   = instr_t'(11), I_LH    = instr_t'(12);
  localparam instr_t I_LW   = instr_t'(13), I_LBU   = instr_t'(14), I_LHU  = instr_t'(15), I_SB    = instr_t'(16);
  localparam instr_t I_SH   = instr_t'(17), I_SW    = instr_t'(18), I_ADDI = instr_t'(19), I_SLTI  = instr_t'(20);
  localparam instr_t I_SLTIU= instr_t'(21), I_XORI  = instr_t'(22), I_ORI  = instr_t'(23), I_ANDI  = instr_t'(24);
  localparam instr_t I_SLLI = instr_t'(25), I_SRLI  = instr_t'(26), I_SRAI = instr_t'(27), I_ADD   = instr_t'(28);
  localparam instr_t I_SUB  = instr_t'(29), I_SLL   = instr_t'(30), I_SLT  = instr_t'(31), I_SLTU  = instr_t'(32);
  localparam instr_t I_XOR  = instr_t'(33), I_SRL   = instr_t'(34), I_SRA  = instr_t'(35), I_OR    = instr_t'(36);
  localparam instr_t I_AND  = instr_t'(37);
`ifdef RISCV_M_EXT_EN
  localparam instr_t I_MUL  = instr_t'(38), I_MULH  = instr_t'(39), I_MULHSU = instr_t'(40), I_MULHU = instr_t'(41);
  localparam instr_t I_DIV  = instr_t'(42), I_DIVU  = instr_t'(43), I_REM    = instr_t'(44), I_REMU  = instr_t'(45);
`endif

  localparam aop_t ALU_ADD = aop_t'(0), ALU_SUB = aop_t'(1), ALU_SLL = aop_t'(2), ALU_SLT = aop_t'(3);
  localparam aop_t ALU_SLTU = aop_t'(4), ALU_XOR = aop_t'(5), ALU_SRL = aop_t'(6), ALU_SRA = aop_t'(7);
  localparam aop_t ALU_OR = aop_t'(8), ALU_AND = aop_t'(9);

  if (MUL_CYCLES < 2 || DIV_CYCLES < 2) begin : g_bad_lat
    $error("MDU latencies must be at least 2");
  end

  typedef struct packed {
    aop_t       alu_op;
    logic [2:0] load_type;
    logic [1:0] store_type;
    logic       write_en, stype, imm_alu, jalr, jal, branch, auipc, lui, zeroflag_inv, mdu_sel;
    logic [4:0] rd;
  } bundle_t;

  bundle_t dec, ex;
  logic    dec_illegal;
  logic    hazard, accept, in_run;
`ifdef RISCV_M_EXT_EN
  logic    dec_mdu, dec_div;
`endif

  always_comb begin
    dec          = '0;
    dec.alu_op   = ALU_ADD;
    dec.rd       = rd_i;
    dec.write_en = 1'b1;
    dec_illegal  = 1'b0;
`ifdef RISCV_M_EXT_EN
    dec_mdu      = 1'b0;
    dec_div      = 1'b0;
`endif
    case (decoded_instr_i)
      I_LUI:   dec.lui = 1'b1;
      I_AUIPC: begin dec.auipc = 1'b1; dec.imm_alu = 1'b1; end
      I_JAL:   dec.jal = 1'b1;
      I_JALR:  dec.jalr = 1'b1;
      I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU: begin
        dec.branch       = 1'b1;
        dec.write_en     = 1'b0;
        dec.zeroflag_inv = (decoded_instr_i == I_BNE) | (decoded_instr_i == I_BGE) |
                           (decoded_instr_i == I_BGEU);
        if (decoded_instr_i == I_BEQ || decoded_instr_i == I_BNE)      dec.alu_op = ALU_SUB;
        else if (decoded_instr_i == I_BLT || decoded_instr_i == I_BGE) dec.alu_op = ALU_SLT;
        else                                                           dec.alu_op = ALU_SLTU;
      end
      I_LB:    begin dec.imm_alu = 1'b1; dec.load_type = 3'b001; end
      I_LBU:   begin dec.imm_alu = 1'b1; dec.load_type = 3'b101; end
      I_LH:    begin dec.imm_alu = 1'b1; dec.load_type = 3'b010; end
      I_LHU:   begin dec.imm_alu = 1'b1; dec.load_type = 3'b110; end
      I_LW:    begin dec.imm_alu = 1'b1; dec.load_type = 3'b100; end
      I_SB, I_SH, I_SW: begin
        dec.imm_alu    = 1'b1;
        dec.stype      = 1'b1;
        dec.write_en   = 1'b0;
        dec.store_type = (decoded_instr_i == I_SB) ? 2'b01 : (decoded_instr_i == I_SH) ? 2'b10 : 2'b11;
      end
      I_ADDI:  dec.imm_alu = 1'b1;
      I_SLTI:  begin dec.imm_alu = 1'b1; dec.alu_op = ALU_SLT;  end
      I_SLTIU: begin dec.imm_alu = 1'b1; dec.alu_op = ALU_SLTU; end
      I_XORI:  begin dec.imm_alu = 1'b1; dec.alu_op = ALU_XOR;  end
      I_ORI:   begin dec.imm_alu = 1'b1; dec.alu_op = ALU_OR;   end
      I_ANDI:  begin dec.imm_alu = 1'b1; dec.alu_op = ALU_AND;  end
      I_SLLI:  begin dec.imm_alu = 1'b1; dec.alu_op = ALU_SLL;  end
      I_SRLI:  begin dec.imm_alu = 1'b1; dec.alu_op = ALU_SRL;  end
      I_SRAI:  begin dec.imm_alu = 1'b1; dec.alu_op = ALU_SRA;  end
      I_ADD:   dec.alu_op = ALU_ADD;
      I_SUB:   dec.alu_op = ALU_SUB;
      I_SLL:   dec.alu_op = ALU_SLL;
      I_SLT:   dec.alu_op = ALU_SLT;
      I_SLTU:  dec.alu_op = ALU_SLTU;
      I_XOR:   dec.alu_op = ALU_XOR;
      I_SRL:   dec.alu_op = ALU_SRL;
      I_SRA:   dec.alu_op = ALU_SRA;
      I_OR:    dec.alu_op = ALU_OR;
      I_AND:   dec.alu_op = ALU_AND;
`ifdef RISCV_M_EXT_EN
      // MDU op is the offset within MUL..REMU, zero-extended into the ALU op field
      I_MUL, I_MULH, I_MULHSU, I_MULHU, I_DIV, I_DIVU, I_REM, I_REMU: begin
        dec_mdu     = 1'b1;
        dec_div     = (decoded_instr_i >= I_DIV);
        dec.mdu_sel = 1'b1;
        dec.alu_op  = aop_t'(3'(decoded_instr_i - I_MUL));
      end
`endif
      default: dec_illegal = 1'b1;
    endcase
  end

  assign hazard     = ex_valid_o & (ex.load_type != 3'b000) & (ex.rd != 5'd0) &
                      ((ex.rd == rs1_i) | (ex.rd == rs2_i));
  assign id_ready_o = rst_n & (flush_i | (in_run & ~hazard & (~ex_valid_o | ex_ready_i)));
  assign accept     = id_valid_i & id_ready_o;

`ifdef RISCV_M_EXT_EN
  localparam int MAX_LAT = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

  typedef enum logic {RUN, MDU_BUSY} state_t;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  assign in_run     = (state == RUN);
  assign mdu_busy_o = (state == MDU_BUSY);
`else
  assign in_run      = 1'b1;
  assign mdu_busy_o  = 1'b0;
  assign mdu_start_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex              <= '0;
      ex.alu_op       <= ALU_ADD;
      ex_valid_o      <= 1'b0;
      illegal_instr_o <= 1'b0;
`ifdef RISCV_M_EXT_EN
      state           <= RUN;
      cnt             <= '0;
      mdu_start_o     <= 1'b0;
`endif
    end else if (flush_i) begin
      // whatever is presented alongside the flush is consumed and dropped
      ex_valid_o      <= 1'b0;
      illegal_instr_o <= 1'b0;
`ifdef RISCV_M_EXT_EN
      state           <= RUN;
      cnt             <= '0;
      mdu_start_o     <= 1'b0;
`endif
    end else begin
      illegal_instr_o <= 1'b0;
`ifdef RISCV_M_EXT_EN
      mdu_start_o     <= 1'b0;
      if (state == MDU_BUSY) begin
        if (cnt == '0) begin
          state      <= RUN;
          ex_valid_o <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end else
`endif
      if (accept) begin
        if (dec_illegal) begin
          ex_valid_o      <= 1'b0;
          illegal_instr_o <= 1'b1;
`ifdef RISCV_M_EXT_EN
        end else if (dec_mdu) begin
          ex          <= dec;
          ex_valid_o  <= 1'b0;
          mdu_start_o <= 1'b1;
          state       <= MDU_BUSY;
          cnt         <= dec_div ? CNT_W'(DIV_CYCLES - 2) : CNT_W'(MUL_CYCLES - 2);
`endif
        end else begin
          ex         <= dec;
          ex_valid_o <= 1'b1;
        end
      end else if (ex_ready_i) begin
        ex_valid_o <= 1'b0;
      end
    end
  end

  assign alu_op_o       = ex.alu_op;
  assign load_type_o    = ex.load_type;
  assign store_type_o   = ex.store_type;
  assign write_en_o     = ex.write_en;
  assign stype_o        = ex.stype;
  assign imm_alu_o      = ex.imm_alu;
  assign jalr_o         = ex.jalr;
  assign jal_o          = ex.jal;
  assign branch_o       = ex.branch;
  assign auipc_o        = ex.auipc;
  assign lui_o          = ex.lui;
  assign zeroflag_inv_o = ex.zeroflag_inv;
  assign mdu_sel_o      = ex.mdu_sel;
  assign ex_rd_o        = ex.rd;

endmodule

// File: tb/tb_ex_ctrl_sequencer.sv
// Directed vector bench for ex_ctrl_sequencer; MDU sequences run when RISCV_M_EXT_EN is defined.
module tb_ex_ctrl_sequencer;
  logic clk = 1'b0, rst_n;
  logic id_valid, id_ready, flush, ex_valid, ex_ready;
  logic [6:0] instr;
  logic [4:0] rd, rs1, rs2, ex_rd;
  logic [5:0] alu_op;
  logic [2:0] load_type;
  logic [1:0] store_type;
  logic write_en, stype, imm_alu, jalr, jal, branch, auipc, lui, zfi, mdu_sel;
  logic mdu_start, mdu_busy, illegal;

  always #5 clk = ~clk;

  ex_ctrl_sequencer dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_ready_o(id_ready),
    .decoded_instr_i(instr), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .flush_i(flush),
    .ex_valid_o(ex_valid), .ex_ready_i(ex_ready), .alu_op_o(alu_op),
    .load_type_o(load_type), .store_type_o(store_type), .write_en_o(write_en),
    .stype_o(stype), .imm_alu_o(imm_alu), .jalr_o(jalr), .jal_o(jal), .branch_o(branch),
    .auipc_o(auipc), .lui_o(lui), .zeroflag_inv_o(zfi), .mdu_sel_o(mdu_sel),
    .ex_rd_o(ex_rd), .mdu_start_o(mdu_start), .mdu_busy_o(mdu_busy),
    .illegal_instr_o(illegal)
  );

  localparam logic [6:0] NOP = 7'd0, LUI = 7'd1, AUIPC = 7'd2, JAL = 7'd3, BNE = 7'd6, BGEU = 7'd10;
  localparam logic [6:0] LW = 7'd13, SW = 7'd18, ADDI = 7'd19, ADD = 7'd28, MUL = 7'd38, DIV = 7'd42;
  localparam logic [6:0] BAD = 7'd127;
  localparam logic [5:0] A_ADD = 6'd0, A_SUB = 6'd1, A_SLTU = 6'd4;
  // flag order: write_en, stype, imm_alu, jalr, jal, branch, auipc, lui, zeroflag_inv, mdu_sel
  localparam logic [9:0] F_IMM = 10'b1010000000, F_R = 10'b1000000000, F_BINV = 10'b0000010010;
  localparam logic [9:0] F_ST = 10'b0110000000, F_LUI = 10'b1000000100, F_JAL = 10'b1000100000;
  localparam logic [9:0] F_AUIPC = 10'b1010001000, F_MDU = 10'b1000000001;

  logic [9:0]  flags;
  logic [4:0]  ctl;
  logic [37:0] all_out;
  assign flags   = {write_en, stype, imm_alu, jalr, jal, branch, auipc, lui, zfi, mdu_sel};
  assign ctl     = {id_ready, ex_valid, illegal, mdu_start, mdu_busy};
  assign all_out = {ctl, alu_op, load_type, store_type, flags, ex_rd, 7'd0};

  typedef struct {
    logic v; logic [6:0] ins; logic [4:0] rd, rs1, rs2; logic fl, rdy;
    logic e_rdy, e_vld, e_ill; logic [5:0] e_alu; logic [2:0] e_ld; logic [1:0] e_st;
    logic [9:0] e_fl; logic [4:0] e_rd;
  } vec_t;

  vec_t vecs[$];
  int n_vec = 0, n_err = 0;

  function automatic vec_t row(logic v, logic [6:0] ins, logic [4:0] rd_, rs1_, rs2_, logic fl, rdy,
                               logic e_rdy, e_vld, e_ill, logic [5:0] e_alu = 0, logic [2:0] e_ld = 0,
                               logic [1:0] e_st = 0, logic [9:0] e_fl = 0, logic [4:0] e_rd = 0);
    vec_t r;
    r.v = v; r.ins = ins; r.rd = rd_; r.rs1 = rs1_; r.rs2 = rs2_; r.fl = fl; r.rdy = rdy;
    r.e_rdy = e_rdy; r.e_vld = e_vld; r.e_ill = e_ill; r.e_alu = e_alu; r.e_ld = e_ld;
    r.e_st = e_st; r.e_fl = e_fl; r.e_rd = e_rd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] ins, input logic [4:0] rd_, rs1_, rs2_,
                       input logic fl, input logic rdy);
    id_valid = v; instr = ins; rd = rd_; rs1 = rs1_; rs2 = rs2_; flush = fl; ex_ready = rdy;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1 drive(0, NOP, 0, 0, 0, 0, 1);
  endtask

  task automatic scan_quiet(input string nm);
    logic seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ex_valid | mdu_start | mdu_busy) seen = 1'b1;
    end
    chk(nm, 64'(seen), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, NOP, 0, 0, 0, 0, 1);
    @(negedge clk); chk("reset_state", 64'(all_out), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    vecs.push_back(row(0, NOP,  0, 0, 0, 0, 1,  1, 0, 0));
    vecs.push_back(row(1, ADDI, 1, 0, 0, 0, 1,  1, 0, 0));
    vecs.push_back(row(1, BNE,  0, 1, 2, 0, 1,  1, 1, 0, A_ADD, 0, 0, F_IMM, 1));
    vecs.push_back(row(0, NOP,  0, 0, 0, 0, 1,  1, 1, 0, A_SUB, 0, 0, F_BINV, 0));
    vecs.push_back(row(1, LW,   5, 2, 0, 0, 1,  1, 0, 0));
    vecs.push_back(row(1, ADD,  6, 5, 2, 0, 1,  0, 1, 0, A_ADD, 3'b100, 0, F_IMM, 5));
    vecs.push_back(row(1, ADD,  6, 5, 2, 0, 1,  1, 0, 0));
    vecs.push_back(row(0, NOP,  0, 0, 0, 0, 1,  1, 1, 0, A_ADD, 0, 0, F_R, 6));
    vecs.push_back(row(1, LW,   0, 3, 0, 0, 1,  1, 0, 0));
    vecs.push_back(row(1, ADD,  7, 0, 0, 0, 1,  1, 1, 0, A_ADD, 3'b100, 0, F_IMM, 0));
    vecs.push_back(row(0, NOP,  0, 0, 0, 0, 1,  1, 1, 0, A_ADD, 0, 0, F_R, 7));
    vecs.push_back(row(1, LUI,  8, 0, 0, 0, 1,  1, 0, 0));
    vecs.push_back(row(1, JAL,  9, 0, 0, 0, 0,  0, 1, 0, A_ADD, 0, 0, F_LUI, 8));
    vecs.push_back(row(1, JAL,  9, 0, 0, 0, 0,  0, 1, 0, A_ADD, 0, 0, F_LUI, 8));
    vecs.push_back(row(1, JAL,  9, 0, 0, 0, 0,  0, 1, 0, A_ADD, 0, 0, F_LUI, 8));
    vecs.push_back(row(1, JAL,  9, 0, 0, 0, 1,  1, 1, 0, A_ADD, 0, 0, F_LUI, 8));
    vecs.push_back(row(0, NOP,  0, 0, 0, 0, 1,  1, 1, 0, A_ADD, 0, 0, F_JAL, 9));
    vecs.push_back(row(1, BAD,  4, 0, 0, 0, 1,  1, 0, 0));
    vecs.push_back(row(0, NOP,  0, 0, 0, 0, 1,  1, 0, 1));
    vecs.push_back(row(0, NOP,  0, 0, 0, 0, 1,  1, 0, 0));
`ifndef RISCV_M_EXT_EN
    vecs.push_back(row(1, MUL, 12, 1, 2, 0, 1,  1, 0, 0));
    vecs.push_back(row(0, NOP,  0, 0, 0, 0, 1,  1, 0, 1));
    vecs.push_back(row(0, NOP,  0, 0, 0, 0, 1,  1, 0, 0));
`endif
    vecs.push_back(row(1, AUIPC, 3, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(row(1, BGEU, 0, 1, 2, 1, 0,  1, 1, 0, A_ADD, 0, 0, F_AUIPC, 3));
    vecs.push_back(row(0, NOP,  0, 0, 0, 0, 1,  1, 0, 0));
    vecs.push_back(row(1, SW,   0, 1, 2, 0, 1,  1, 0, 0));
    vecs.push_back(row(1, BGEU, 0, 1, 2, 0, 1,  1, 1, 0, A_ADD, 0, 2'b11, F_ST, 0));
    vecs.push_back(row(0, NOP,  0, 0, 0, 0, 1,  1, 1, 0, A_SLTU, 0, 0, F_BINV, 0));
    vecs.push_back(row(0, NOP,  0, 0, 0, 0, 1,  1, 0, 0));

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i].v, vecs[i].ins, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].fl, vecs[i].rdy);
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i), 64'(ctl), 64'({vecs[i].e_rdy, vecs[i].e_vld, vecs[i].e_ill, 2'b00}));
      if (vecs[i].e_vld)
        chk($sformatf("vec%0d_bundle", i), 64'({alu_op, load_type, store_type, flags, ex_rd}),
            64'({vecs[i].e_alu, vecs[i].e_ld, vecs[i].e_st, vecs[i].e_fl, vecs[i].e_rd}));
    end

`ifdef RISCV_M_EXT_EN
    // DIV: start at +1, busy +1..+33, result at +34
    @(posedge clk); #1 drive(1, DIV, 10, 1, 2, 0, 1);
    @(negedge clk); chk("div_accept_ready", 64'(id_ready), 64'd1);
    for (int k = 1; k <= 34; k++) begin
      idle_cycle();
      @(negedge clk);
      chk($sformatf("div_k%0d", k), 64'({ex_valid, mdu_start, mdu_busy, id_ready}),
          64'({k == 34, k == 1, k <= 33, k == 34}));
      if (k == 34)
        chk("div_bundle", 64'({alu_op, flags, ex_rd}), 64'({6'd4, F_MDU, 5'd10}));
    end
    @(posedge clk); #1 drive(1, MUL, 12, 1, 2, 0, 1);
    for (int k = 1; k <= 2; k++) begin
      idle_cycle();
      @(negedge clk);
      chk($sformatf("mul_k%0d", k), 64'({ex_valid, mdu_start, mdu_busy}),
          64'({k == 2, k == 1, k == 1}));
      if (k == 2) chk("mul_bundle", 64'({alu_op, flags, ex_rd}), 64'({6'd0, F_MDU, 5'd12}));
    end
    // flush at cycle 10 of a DIV, with an ADDI presented alongside
    @(posedge clk); #1 drive(1, DIV, 10, 1, 2, 0, 1);
    repeat (9) idle_cycle();
    @(posedge clk); #1 drive(1, ADDI, 11, 0, 0, 1, 1);
    @(negedge clk); chk("flush_cycle", 64'({id_ready, mdu_busy}), 64'b11);
    idle_cycle();
    @(negedge clk); chk("flush_after", 64'(ctl), 64'b10000);
    scan_quiet("flush_no_late_result");
    // async reset mid-MDU
    @(posedge clk); #1 drive(1, DIV, 10, 1, 2, 0, 1);
    repeat (5) idle_cycle();
    @(posedge clk); #1 rst_n = 1'b0;
    #1 chk("reset_mid_mdu", 64'(all_out), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk); chk("reset_mid_mdu_ready", 64'(ctl), 64'b10000);
    scan_quiet("reset_mid_mdu_quiet");
`endif

    // async reset while a bundle is being held
    @(posedge clk); #1 drive(1, LUI, 8, 0, 0, 0, 0);
    @(posedge clk); #1 drive(0, NOP, 0, 0, 0, 0, 0);
    @(negedge clk); chk("hold_before_reset", 64'({ex_valid, lui, ex_rd}), 64'({1'b1, 1'b1, 5'd8}));
    @(posedge clk); #1 rst_n = 1'b0;
    #1 chk("reset_mid_hold", 64'(all_out), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    ex_ready = 1'b1;
    @(negedge clk); chk("reset_release_ready", 64'(ctl), 64'b10000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
